// File: rtl/ps2_poly_note_decoder_pkg.sv
// Shared scan-code constants, prefix-FSM encoding and note-code helpers for the PS/2 polyphonic decoder.
// Pure declarations: no latency, no flow control.
package ps2_poly_note_decoder_pkg;

  localparam int NOTE_W = 7;
  localparam int SEMI_W = 4;
  localparam int AGE_W  = 3;
  localparam int VIDX_W = 3;
  localparam int OCT_W  = 3;

  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_OCT_DN = 8'h1A;
  localparam logic [7:0] SC_OCT_UP = 8'h22;

  // Index s holds the set-2 code for semitone s (A at 0 .. G# at 11).
  localparam logic [11:0][7:0] KEYMAP = {
    8'h42, 8'h3B, 8'h3C, 8'h33, 8'h34, 8'h2C,
    8'h2B, 8'h2D, 8'h23, 8'h1B, 8'h1D, 8'h1C
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_state_e;

  function automatic logic [NOTE_W-1:0] note_code(input logic [OCT_W-1:0] oct,
                                                  input logic [SEMI_W-1:0] semi);
    return NOTE_W'(oct) * NOTE_W'(12) + NOTE_W'(semi);
  endfunction

endpackage

// File: rtl/ps2_poly_note_decoder_keymap.sv
// Combinational scan-code lookup: semitone for note keys, flags for the octave keys.
// Zero latency, no flow control.
module ps2_keymap
  import ps2_poly_note_decoder_pkg::*;
(
  input  logic [7:0]        i_scan_code,
  output logic              valid,
  output logic [SEMI_W-1:0] semitone,
  output logic              oct_up,
  output logic              oct_dn
);

  always_comb begin
    valid    = 1'b0;
    semitone = '0;
    oct_up   = (i_scan_code == SC_OCT_UP);
    oct_dn   = (i_scan_code == SC_OCT_DN);
    for (int s = 0; s < 12; s++) begin
      if (i_scan_code == KEYMAP[s]) begin
        valid    = 1'b1;
        semitone = SEMI_W'(s);
      end
    end
  end

endmodule

// File: rtl/ps2_poly_note_decoder.sv
// PS/2 set-2 scan codes to a polyphonic voice table with oldest-voice stealing and octave shift.
// One-cycle latency from strobe to outputs; every strobe is accepted, no backpressure.
module ps2_poly_note_decoder
  import ps2_poly_note_decoder_pkg::*;
#(
  parameter int NUM_VOICES   = 4,
  parameter int STEAL_OLDEST = 1,
  parameter int OCT_INIT     = 4
)(
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic [7:0]                   received_data,
  input  logic                         received_data_en,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic                         note_on,
  output logic                         note_off,
  output logic [VIDX_W-1:0]            event_voice,
  output logic [OCT_W-1:0]             octave
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

  prefix_state_e r_state;
  prefix_state_e w_state_nxt;

  logic [NUM_VOICES-1:0] r_active;
  logic [NOTE_W-1:0]     r_note [NUM_VOICES];
  logic [SEMI_W-1:0]     r_semi [NUM_VOICES];
  logic [AGE_W-1:0]      r_age  [NUM_VOICES];
  logic                  r_note_on;
  logic                  r_note_off;
  logic [VIDX_W-1:0]     r_event_voice;
  logic [OCT_W-1:0]      r_octave;

  logic              w_make, w_brk;
  logic              w_kvalid, w_oct_up, w_oct_dn;
  logic [SEMI_W-1:0] w_semi;
  logic              w_held, w_free;
  logic [VIDX_W-1:0] w_held_idx, w_free_idx, w_old_idx, w_tgt;
  logic [AGE_W-1:0]  w_old_age;
  logic              w_assign, w_release;

  ps2_keymap u_keymap (
    .i_scan_code (received_data),
    .valid       (w_kvalid),
    .semitone    (w_semi),
    .oct_up      (w_oct_up),
    .oct_dn      (w_oct_dn)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    if (received_data_en) begin
      if (received_data == SC_EXT) begin
        w_state_nxt = ST_EXT;
      end else if (received_data == SC_BRK) begin
        case (r_state)
          ST_IDLE: w_state_nxt = ST_BRK;
          ST_EXT:  w_state_nxt = ST_EXT_BRK;
          default: w_state_nxt = r_state;
        endcase
      end else begin
        // Extended-key bytes land here too and are dropped.
        w_state_nxt = ST_IDLE;
        w_make      = (r_state == ST_IDLE);
        w_brk       = (r_state == ST_BRK);
      end
    end
  end

  always_comb begin
    w_held     = 1'b0;
    w_held_idx = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (r_active[v] && (r_semi[v] == w_semi)) begin
        w_held     = 1'b1;
        w_held_idx = VIDX_W'(v);
      end
      if (!r_active[v]) begin
        w_free     = 1'b1;
        w_free_idx = VIDX_W'(v);
      end
    end
    // Strict compare keeps the lowest index on equal ages.
    w_old_idx = '0;
    w_old_age = r_age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (r_age[v] > w_old_age) begin
        w_old_idx = VIDX_W'(v);
        w_old_age = r_age[v];
      end
    end
  end

  always_comb begin
    w_assign = 1'b0;
    w_tgt    = w_free_idx;
    if (w_make && w_kvalid && !w_held) begin
      if (w_free) begin
        w_assign = 1'b1;
      end else if (STEAL_OLDEST != 0) begin
        w_assign = 1'b1;
        w_tgt    = w_old_idx;
      end
    end
    w_release = w_brk && w_kvalid && w_held;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_active      <= '0;
      r_note_on     <= 1'b0;
      r_note_off    <= 1'b0;
      r_event_voice <= '0;
      r_octave      <= OCT_W'(OCT_INIT);
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_note[v] <= '0;
        r_semi[v] <= '0;
        r_age[v]  <= '0;
      end
    end else begin
      r_note_on  <= w_assign;
      r_note_off <= w_release;
      if (w_assign)       r_event_voice <= w_tgt;
      else if (w_release) r_event_voice <= w_held_idx;

      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_assign) begin
          if (VIDX_W'(v) == w_tgt) begin
            r_active[v] <= 1'b1;
            r_note[v]   <= note_code(r_octave, w_semi);
            r_semi[v]   <= w_semi;
            r_age[v]    <= '0;
          end else if (r_active[v] && (r_age[v] != AGE_MAX)) begin
            r_age[v] <= r_age[v] + 1'b1;
          end
        end
        if (w_release && (VIDX_W'(v) == w_held_idx)) begin
          r_active[v] <= 1'b0;
          r_note[v]   <= '0;
          r_age[v]    <= '0;
        end
      end

      if (w_make && w_oct_up && (r_octave != OCT_W'(7))) r_octave <= r_octave + 1'b1;
      if (w_make && w_oct_dn && (r_octave != '0))        r_octave <= r_octave - 1'b1;
    end
  end

  always_comb begin
    voice_note = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note[NOTE_W*v +: NOTE_W] = r_note[v];
    end
  end

  assign voice_active = r_active;
  assign note_on      = r_note_on;
  assign note_off     = r_note_off;
  assign event_voice  = r_event_voice;
  assign octave       = r_octave;

endmodule

// File: doc/ps2_poly_note_decoder.md
PS2_POLY_NOTE_DECODER -- requirements
Module: ps2_poly_note_decoder

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of polyphonic voice slots, legal 1..8.
REQ-002 SHALL have parameter STEAL_OLDEST, default 1; 1 = steal oldest voice when all busy, 0 = drop the new note.
REQ-003 SHALL have parameter OCT_INIT, default 4, octave after reset, legal 0..7.
REQ-004 CLOCK_50  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 received_data  input  8  PS/2 scan-code byte (set 2) from the PS/2 receiver.
REQ-007 received_data_en  input  1  one-cycle strobe qualifying received_data.
REQ-008 voice_active  output  NUM_VOICES  bit v = voice v holds a sounding note.
REQ-009 voice_note  output  7*NUM_VOICES  voice v note code at bits [7v+6:7v], code = octave*12 + semitone.
REQ-010 note_on  output  1  one-cycle pulse: a voice was (re)assigned.
REQ-011 note_off  output  1  one-cycle pulse: a voice was released.
REQ-012 event_voice  output  3  voice index of the current note_on/note_off pulse; holds last value otherwise.
REQ-013 octave  output  3  current octave.

Function
REQ-014 Keymap, semitone 0..11: 1C,1D,1B,23,2D,2B,2C,34,33,3C,3B,42 (A, A#, B, C, C#, D, D#, E, F, F#, G, G#); 1A = octave down, 22 = octave up; all other codes unmapped.
REQ-015 Prefix FSM states IDLE, BRK, EXT, EXT_BRK; transitions occur only on received_data_en.
REQ-016 F0: IDLE->BRK, EXT->EXT_BRK; E0: any state->EXT; repeated F0 in BRK/EXT_BRK holds state.
REQ-017 Any other byte in EXT or EXT_BRK is discarded; FSM -> IDLE.
REQ-018 Any other byte in IDLE is a make; in BRK it is a break; FSM -> IDLE after either.
REQ-019 Make of mapped note already held (semitone match) is ignored (typematic repeat).
REQ-020 Make of new mapped note: assign lowest-index free voice, code from current octave.
REQ-021 No free voice, STEAL_OLDEST=1: overwrite the active voice with greatest age, ties to lowest index, single note_on, no note_off; STEAL_OLDEST=0: no change, no pulse.
REQ-022 Age: per-voice counter, saturating at NUM_VOICES-1; on assignment the chosen voice gets 0 and every other active voice increments.
REQ-023 Break of mapped note clears the voice holding that semitone, independent of octave at press time; pulses note_off.
REQ-024 Break of an unheld or unmapped note produces no change and no pulse.
REQ-025 Octave make: decrement/increment, clamped at 0/7; held voices keep their codes; break of 1A/22 ignored.
REQ-026 Latency: outputs and pulses update on the clock edge after the one sampling the strobe, i.e. one cycle.
REQ-027 At most one note event per strobe; note_on and note_off never both high.
REQ-028 All outputs registered; no combinational input-to-output path.

Reset
REQ-029 reset SHALL clear FSM to IDLE, voice_active, voice_note, ages, note_on, note_off, event_voice to 0, octave to OCT_INIT.
REQ-030 reset SHALL override a coincident received_data_en; a prefix pending at reset is discarded.

Structure
REQ-031 A shared package/include SHALL hold scan-code constants (F0, E0, keymap, octave keys), FSM state encodings and the note-code width 7.
REQ-032 The scan-code-to-semitone lookup SHALL be a combinational sub-module ps2_keymap (outputs valid, semitone, oct_up, oct_dn).

Verification
REQ-033 Reset, strobe 1C -> next cycle voice_active=0001, voice 0 code 48, note_on=1, event_voice=0.
REQ-034 Strobes 1C,1C,F0,1C -> single note_on on first strobe only; after break voice_active=0000, note_off=1 once.
REQ-035 NUM_VOICES=4, STEAL_OLDEST=1: make 1C,1D,1B,23,2D -> 2D (code 52) replaces voice 0, event_voice=0, no note_off.
REQ-036 STEAL_OLDEST=0, same stimulus -> fifth make ignored, voice_active=1111, no pulse.
REQ-037 Make 1C, make 22, F0 1C -> voice 0 released; octave=5; make 1C -> code 60; eight 22 makes -> octave stays 7.
REQ-038 E0,1C then E0,F0,1C, then reset asserted with a pending F0 -> no voice change; next 1C is a make.
